// File: rtl/ps2_keyboard_fifo_if.sv
// -----------------------------------------------------------------------------
// ps2_keyboard_fifo_if
// PicoBlaze I/O bus as seen by the PS/2 keyboard FIFO.
//   Port_ID         : port address driven by the processor
//   Read_Strobe     : read strobe driven by the processor
//   Keyboard_Output : registered read data returned to the processor
//   Key_Ready       : high while the keyboard FIFO holds at least one entry
// master = processor side, slave = keyboard block side.
// -----------------------------------------------------------------------------
interface ps2_keyboard_fifo_if;
   logic [7:0] Port_ID;
   logic       Read_Strobe;
   logic [7:0] Keyboard_Output;
   logic       Key_Ready;

   modport master (output Port_ID, Read_Strobe, input  Keyboard_Output, Key_Ready);
   modport slave  (input  Port_ID, Read_Strobe, output Keyboard_Output, Key_Ready);
endinterface

// File: rtl/ps2_keyboard_fifo.sv
// -----------------------------------------------------------------------------
// ps2_keyboard_fifo
// PS/2 keyboard receiver: synchronises and glitch-filters the PS/2 lines,
// receives 11-bit frames (start, 8 data LSB-first, odd parity, stop), folds
// E0/F0 prefixes into tagged entries {brk, ext, scan_code} and buffers them in
// a FIFO that the PicoBlaze reads through four consecutive port IDs:
//   BASE+0 STATUS : {empty, overflow, parity_err, frame_err, count[3:0]}
//   BASE+1 DATA   : head scan code (8'h00 when empty)
//   BASE+2 FLAGS  : {head brk, head ext, 6'b0} (8'h00 when empty); strobe pops
//   BASE+3 CLEAR  : reads STATUS; strobe clears the sticky error flags
// Ports:
//   CLK       : system clock, rising edge
//   RESET     : synchronous, active-low reset
//   PS2_Clock : PS/2 clock line, asynchronous
//   PS2_Data  : PS/2 data line, asynchronous
//   bus       : PicoBlaze bus (Port_ID, Read_Strobe, Keyboard_Output, Key_Ready)
// FIFO_DEPTH must be 2, 4 or 8.
// -----------------------------------------------------------------------------
module ps2_keyboard_fifo #(
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter logic [7:0]  BASE_PORT      = 8'h05,
   parameter bit          PARITY_EN      = 1'b1,
   parameter bit          REPORT_BREAK   = 1'b1,
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 200000
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               PS2_Clock,
   input  logic               PS2_Data,
   ps2_keyboard_fifo_if.slave bus
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [7:0] PORT_STATUS = BASE_PORT;
   localparam logic [7:0] PORT_DATA   = BASE_PORT + 8'd1;
   localparam logic [7:0] PORT_FLAGS  = BASE_PORT + 8'd2;
   localparam logic [7:0] PORT_CLEAR  = BASE_PORT + 8'd3;

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;

   // ---------------------------------------------------------------- inputs
   logic [1:0]    clk_sync, dat_sync;
   logic          ps2c, ps2d;
   logic          filt_level, filt_flip, ps2_fall;
   logic [FW-1:0] filt_cnt;

   // NOTE: every clocked register uses non-blocking assignment so all state
   // updates see the pre-edge values and simulation matches the netlist.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
      end else begin
         clk_sync <= {clk_sync[0], PS2_Clock};
         dat_sync <= {dat_sync[0], PS2_Data};
      end
   end

   assign ps2c = clk_sync[1];
   assign ps2d = dat_sync[1];

   // The filtered level only flips after FILTER_LEN consecutive samples that
   // disagree with it; a falling flip is the bit-sampling event.
   assign filt_flip = (ps2c != filt_level) && (filt_cnt == FW'(FILTER_LEN - 1));
   assign ps2_fall  = filt_flip && filt_level;

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         filt_level <= 1'b1;
         filt_cnt   <= '0;
      end else if (ps2c == filt_level) begin
         filt_cnt   <= '0;
      end else if (filt_flip) begin
         filt_level <= ps2c;
         filt_cnt   <= '0;
      end else begin
         filt_cnt   <= filt_cnt + FW'(1);
      end
   end

   // -------------------------------------------------------------- receiver
   rx_state_t     state, state_next;
   logic [7:0]    shift_reg, rx_byte;
   logic [2:0]    bit_cnt;
   logic          parity_bit, parity_ok, timeout;
   logic [TW-1:0] timer;
   logic          byte_ok, set_frame_err, set_parity_err, rx_valid;

   assign parity_ok = ^{shift_reg, parity_bit};
   assign timeout   = (state != S_IDLE) && !ps2_fall && (timer == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CLK) begin
      if (!RESET) state <= S_IDLE;
      else        state <= state_next;
   end

   // NOTE: each combinational block assigns a default to every output first,
   // so no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      if (timeout) begin
         state_next = S_IDLE;
      end else if (ps2_fall) begin
         case (state)
            S_IDLE:   if (!ps2d) state_next = S_DATA;
            S_DATA:   if (bit_cnt == 3'd7) state_next = S_PARITY;
            S_PARITY: state_next = S_STOP;
            default:  state_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      byte_ok        = 1'b0;
      set_frame_err  = 1'b0;
      set_parity_err = 1'b0;
      if (timeout) begin
         set_frame_err = 1'b1;
      end else if (ps2_fall && state == S_STOP) begin
         if (ps2d && (parity_ok || !PARITY_EN)) begin
            byte_ok = 1'b1;
         end else begin
            set_frame_err  = !ps2d;
            set_parity_err = PARITY_EN && !parity_ok;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         shift_reg  <= '0;
         bit_cnt    <= '0;
         parity_bit <= 1'b0;
         timer      <= '0;
         rx_valid   <= 1'b0;
         rx_byte    <= '0;
      end else begin
         rx_valid <= byte_ok;
         if (byte_ok) rx_byte <= shift_reg;
         timer <= (state == S_IDLE || ps2_fall) ? '0 : timer + TW'(1);
         if (ps2_fall) begin
            case (state)
               S_IDLE: bit_cnt <= '0;
               S_DATA: begin
                  shift_reg <= {ps2d, shift_reg[7:1]};
                  bit_cnt   <= bit_cnt + 3'd1;
               end
               S_PARITY: parity_bit <= ps2d;
               default: ;
            endcase
         end
      end
   end

   // --------------------------------------------------------------- decoder
   logic       ext_pend, brk_pend, is_ext, is_brk, dec_push;
   logic [9:0] dec_entry;

   assign is_ext    = (rx_byte == 8'hE0);
   assign is_brk    = (rx_byte == 8'hF0);
   assign dec_push  = rx_valid && !is_ext && !is_brk && (REPORT_BREAK || !brk_pend);
   assign dec_entry = {brk_pend, ext_pend, rx_byte};

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         ext_pend <= 1'b0;
         brk_pend <= 1'b0;
      end else if (rx_valid) begin
         if (is_ext)      ext_pend <= 1'b1;
         else if (is_brk) brk_pend <= 1'b1;
         else begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------ fifo
   logic [9:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          empty, full, strobe_q, strobe_rise, pop, clear, wr_en, ovf_set;
   logic          overflow, parity_err, frame_err;
   logic [9:0]    head;
   logic [7:0]    status, rd_mux;

   assign empty       = (count == '0);
   assign full        = (count == CW'(FIFO_DEPTH));
   assign strobe_rise = bus.Read_Strobe && !strobe_q;
   assign pop         = strobe_rise && (bus.Port_ID == PORT_FLAGS) && !empty;
   assign clear       = strobe_rise && (bus.Port_ID == PORT_CLEAR);
   // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
   assign wr_en       = dec_push && (!full || pop);
   assign ovf_set     = dec_push && full && !pop;
   assign head        = mem[rd_ptr];
   assign status      = {empty, overflow, parity_err, frame_err, 4'(count)};

   // NOTE: the storage array has no reset; count and pointers decide which
   // words are valid, and leaving it out of reset lets it map to RAM.
   always_ff @(posedge CLK) begin
      if (wr_en) mem[wr_ptr] <= dec_entry;
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   // Sticky flags: a set in the same cycle as a clear wins.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         overflow   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         overflow   <= ovf_set        || (overflow   && !clear);
         parity_err <= set_parity_err || (parity_err && !clear);
         frame_err  <= set_frame_err  || (frame_err  && !clear);
      end
   end

   // ------------------------------------------------------------- read port
   always_comb begin
      rd_mux = 8'h00;
      if (bus.Port_ID == PORT_STATUS || bus.Port_ID == PORT_CLEAR) rd_mux = status;
      else if (bus.Port_ID == PORT_DATA)  rd_mux = empty ? 8'h00 : head[7:0];
      else if (bus.Port_ID == PORT_FLAGS) rd_mux = empty ? 8'h00 : {head[9:8], 6'b0};
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         bus.Keyboard_Output <= 8'h00;
         bus.Key_Ready       <= 1'b0;
         strobe_q            <= 1'b0;
      end else begin
         bus.Keyboard_Output <= rd_mux;
         bus.Key_Ready       <= !empty;
         strobe_q            <= bus.Read_Strobe;
      end
   end

endmodule

// File: tb/tb_ps2_keyboard_fifo.sv
// -----------------------------------------------------------------------------
// tb_ps2_keyboard_fifo
// Two instances share one PS/2 line pair and one PicoBlaze bus drive:
//   dut_a : PARITY_EN=1, REPORT_BREAK=1
//   dut_b : PARITY_EN=0, REPORT_BREAK=0
// A table of directed operations (reset / send frame / read port / check
// Key_Ready) with hand-computed expectations is applied in a loop, followed by
// hand-written sequences for timeout, reset mid-frame and a long strobe.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_keyboard_fifo;

   localparam int         HALF = 10;    // PS/2 half bit period in CLK cycles
   localparam int         FL   = 4;
   localparam int         TO   = 100;
   localparam logic [7:0] BASE     = 8'h05;
   localparam logic [7:0] P_STATUS = BASE;
   localparam logic [7:0] P_DATA   = BASE + 8'd1;
   localparam logic [7:0] P_FLAGS  = BASE + 8'd2;
   localparam logic [7:0] P_CLEAR  = BASE + 8'd3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_dat = 1'b1;
   logic [7:0] port_id = 8'h00;
   logic       read_strobe = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ps2_keyboard_fifo_if bus_a ();
   ps2_keyboard_fifo_if bus_b ();

   assign bus_a.Port_ID     = port_id;
   assign bus_a.Read_Strobe = read_strobe;
   assign bus_b.Port_ID     = port_id;
   assign bus_b.Read_Strobe = read_strobe;

   ps2_keyboard_fifo #(
      .FIFO_DEPTH(8), .BASE_PORT(BASE), .PARITY_EN(1'b1), .REPORT_BREAK(1'b1),
      .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)
   ) dut_a (
      .CLK(clk), .RESET(rst_n), .PS2_Clock(ps2_clk), .PS2_Data(ps2_dat), .bus(bus_a)
   );

   ps2_keyboard_fifo #(
      .FIFO_DEPTH(8), .BASE_PORT(BASE), .PARITY_EN(1'b0), .REPORT_BREAK(1'b0),
      .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)
   ) dut_b (
      .CLK(clk), .RESET(rst_n), .PS2_Clock(ps2_clk), .PS2_Data(ps2_dat), .bus(bus_b)
   );

   typedef enum logic [1:0] {OP_RESET, OP_SEND, OP_READ, OP_READY} op_kind_t;

   typedef struct {
      op_kind_t   kind;
      logic [7:0] val;      // frame byte or port id
      logic       par_bad;  // send: invert the parity bit
      logic       pop;      // read: strobe once after the read
      logic [7:0] exp_a;
      logic       chk_b;
      logic [7:0] exp_b;
      string      name;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(op_kind_t k, logic [7:0] v, logic pb, logic p,
                               logic [7:0] ea, logic cb, logic [7:0] eb, string n);
      vec_t t;
      t.kind = k; t.val = v; t.par_bad = pb; t.pop = p;
      t.exp_a = ea; t.chk_b = cb; t.exp_b = eb; t.name = n;
      vecs.push_back(t);
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h, expected %02h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Bits go out LSB first; clock low for HALF cycles per bit.
   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_dat = bits[i];
         tick(HALF);
         ps2_clk = 1'b0;
         tick(HALF);
         ps2_clk = 1'b1;
      end
      ps2_dat = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par_bad);
      logic par;
      par = (~^b) ^ par_bad;
      send_bits({1'b1, par, b, 1'b0}, 11);
      tick(2 * HALF);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic read_port(input logic [7:0] p, output logic [7:0] a, output logic [7:0] b);
      port_id = p;
      tick(2);
      @(negedge clk);
      a = bus_a.Keyboard_Output;
      b = bus_b.Keyboard_Output;
   endtask

   task automatic strobe(input int n);
      @(posedge clk);
      #1;
      read_strobe = 1'b1;
      tick(n);
      read_strobe = 1'b0;
      tick(2);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, expected $finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] ra, rb;

      // Idle after reset
      add(OP_RESET, 8'h00, 0, 0, 8'h00, 0, 8'h00, "reset");
      add(OP_READ,  P_STATUS, 0, 0, 8'h80, 1, 8'h80, "idle_status");
      add(OP_READ,  P_DATA,   0, 0, 8'h00, 1, 8'h00, "idle_data");
      add(OP_READ,  P_FLAGS,  0, 0, 8'h00, 1, 8'h00, "idle_flags");
      add(OP_READY, 8'h00, 0, 0, 8'h00, 1, 8'h00, "idle_ready");
      // 78, F0 78: make + break (dut_b drops the break)
      add(OP_SEND, 8'h78, 0, 0, 0, 0, 0, "");
      add(OP_SEND, 8'hF0, 0, 0, 0, 0, 0, "");
      add(OP_SEND, 8'h78, 0, 0, 0, 0, 0, "");
      add(OP_READY, 8'h00, 0, 0, 8'h01, 1, 8'h01, "mk_brk_ready");
      add(OP_READ, P_STATUS, 0, 0, 8'h02, 1, 8'h01, "mk_brk_status");
      add(OP_READ, P_DATA,   0, 0, 8'h78, 1, 8'h78, "mk_data");
      add(OP_READ, P_FLAGS,  0, 1, 8'h00, 1, 8'h00, "mk_flags");
      add(OP_READ, P_DATA,   0, 0, 8'h78, 1, 8'h00, "brk_data");
      add(OP_READ, P_FLAGS,  0, 1, 8'h80, 1, 8'h00, "brk_flags");
      add(OP_READ, P_STATUS, 0, 0, 8'h80, 1, 8'h80, "mk_brk_empty");
      add(OP_READY, 8'h00, 0, 0, 8'h00, 1, 8'h00, "mk_brk_ready0");
      // E0 75, E0 F0 75
      add(OP_SEND, 8'hE0, 0, 0, 0, 0, 0, "");
      add(OP_SEND, 8'h75, 0, 0, 0, 0, 0, "");
      add(OP_SEND, 8'hE0, 0, 0, 0, 0, 0, "");
      add(OP_SEND, 8'hF0, 0, 0, 0, 0, 0, "");
      add(OP_SEND, 8'h75, 0, 0, 0, 0, 0, "");
      add(OP_READ, P_STATUS, 0, 0, 8'h02, 1, 8'h01, "ext_status");
      add(OP_READ, P_DATA,   0, 0, 8'h75, 1, 8'h75, "ext_data");
      add(OP_READ, P_FLAGS,  0, 1, 8'h40, 1, 8'h40, "ext_flags");
      add(OP_READ, P_DATA,   0, 0, 8'h75, 1, 8'h00, "extbrk_data");
      add(OP_READ, P_FLAGS,  0, 1, 8'hC0, 1, 8'h00, "extbrk_flags");
      add(OP_READ, P_STATUS, 0, 0, 8'h80, 1, 8'h80, "ext_empty");
      // Nine makes into an 8-deep FIFO
      for (int i = 0; i < 9; i++) add(OP_SEND, 8'h16, 0, 0, 0, 0, 0, "");
      add(OP_READ, P_STATUS, 0, 0, 8'h48, 1, 8'h48, "ovf_status");
      add(OP_READ, P_CLEAR,  0, 1, 8'h48, 1, 8'h48, "ovf_clear_read");
      add(OP_READ, P_STATUS, 0, 0, 8'h08, 1, 8'h08, "ovf_cleared");
      for (int i = 0; i < 8; i++) begin
         add(OP_READ, P_DATA,  0, 0, 8'h16, 1, 8'h16, $sformatf("drain_data%0d", i));
         add(OP_READ, P_FLAGS, 0, 1, 8'h00, 1, 8'h00, $sformatf("drain_flags%0d", i));
      end
      add(OP_READ, P_STATUS, 0, 0, 8'h80, 1, 8'h80, "drain_empty");
      // Bad parity on 1E
      add(OP_SEND, 8'h1E, 1, 0, 0, 0, 0, "");
      add(OP_READ, P_STATUS, 0, 0, 8'hA0, 1, 8'h01, "parity_status");
      add(OP_READ, P_DATA,   0, 0, 8'h00, 1, 8'h1E, "parity_data");
      add(OP_READ, 8'h09,    0, 0, 8'h00, 1, 8'h00, "other_port");

      foreach (vecs[i]) begin
         case (vecs[i].kind)
            OP_RESET: do_reset();
            OP_SEND:  send_frame(vecs[i].val, vecs[i].par_bad);
            OP_READ: begin
               read_port(vecs[i].val, ra, rb);
               check({vecs[i].name, "_a"}, ra, vecs[i].exp_a);
               if (vecs[i].chk_b) check({vecs[i].name, "_b"}, rb, vecs[i].exp_b);
               if (vecs[i].pop) strobe(1);
            end
            default: begin
               @(negedge clk);
               check({vecs[i].name, "_a"}, 8'(bus_a.Key_Ready), vecs[i].exp_a);
               check({vecs[i].name, "_b"}, 8'(bus_b.Key_Ready), vecs[i].exp_b);
            end
         endcase
      end

      // Reset while dut_a shows A0 and dut_b holds an entry: outputs forced low.
      port_id = P_STATUS;
      tick(2);
      rst_n = 1'b0;
      tick(2);
      @(negedge clk);
      check("in_reset_out_a", bus_a.Keyboard_Output, 8'h00);
      check("in_reset_ready_b", 8'(bus_b.Key_Ready), 8'h00);
      rst_n = 1'b1;
      tick(2);

      // Timeout: start + 4 data bits, then the clock stays high.
      send_bits({2'b11, 8'h5A, 1'b0}, 5);
      tick(TO + 40);
      read_port(P_STATUS, ra, rb);
      check("timeout_status", ra, 8'h90);
      send_frame(8'h5A, 1'b0);
      read_port(P_DATA, ra, rb);
      check("timeout_next_data", ra, 8'h5A);
      port_id = P_FLAGS;
      strobe(1);
      read_port(P_STATUS, ra, rb);
      check("timeout_after_pop", ra, 8'h90);

      // Reset in the middle of a frame.
      send_bits({2'b11, 8'h33, 1'b0}, 6);
      do_reset();
      read_port(P_STATUS, ra, rb);
      check("midreset_status", ra, 8'h80);
      send_frame(8'h5A, 1'b0);
      read_port(P_DATA, ra, rb);
      check("midreset_next_data", ra, 8'h5A);
      port_id = P_FLAGS;
      strobe(1);
      read_port(P_STATUS, ra, rb);
      check("midreset_after_pop", ra, 8'h80);

      // A 20-cycle strobe on FLAGS pops exactly one entry.
      send_frame(8'h1C, 1'b0);
      send_frame(8'h5A, 1'b0);
      read_port(P_STATUS, ra, rb);
      check("long_pre_status", ra, 8'h02);
      port_id = P_FLAGS;
      strobe(20);
      read_port(P_STATUS, ra, rb);
      check("long_post_status", ra, 8'h01);
      read_port(P_DATA, ra, rb);
      check("long_post_data", ra, 8'h5A);
      port_id = P_FLAGS;
      strobe(1);
      read_port(P_STATUS, ra, rb);
      check("long_final_status", ra, 8'h80);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
